// File: rtl/jelly_bean_pkg.sv
// Shared encodings and constants for the jelly bean taster.
// Field widths here match the bus encodings exactly.
package jelly_bean_pkg;

    localparam int NUM_FLAVORS   = 4;
    localparam int TASTE_LATENCY = 2;

    typedef enum logic [2:0] {
        NO_FLAVOR  = 3'd0,
        APPLE      = 3'd1,
        BLUEBERRY  = 3'd2,
        BUBBLE_GUM = 3'd3,
        CHOCOLATE  = 3'd4
    } flavor_e;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        NO_TASTE = 2'd0,
        YUMMY    = 2'd1,
        YUCKY    = 2'd2
    } taste_e;

    // Flavor codes 5..7 are illegal and never count as a bean.
    function automatic logic is_present(input logic [2:0] f);
        return (f >= 3'd1) && (f <= 3'd4);
    endfunction

endpackage

// File: rtl/jelly_bean_stat_counter.sv
// Saturating statistics counter; clear takes priority over increment.
module jelly_bean_stat_counter
    import jelly_bean_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/jelly_bean_taster_core.sv
// Two-stage jelly bean judge with sour fatigue and per-flavor statistics.
// Stage 1 samples the bus; stage 2 evaluates, tracks fatigue and bumps counters.
module jelly_bean_taster_core
    import jelly_bean_pkg::*;
#(
    parameter int SOUR_LIMIT  = 3,
    parameter int NUMB_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       flavor,
    input  logic [1:0]       color,
    input  logic             sugar_free,
    input  logic             sour,
    output logic [1:0]       taste,
    output logic             numb,
    input  logic [2:0]       stat_sel,
    output logic [CNT_W-1:0] stat_yummy,
    output logic [CNT_W-1:0] stat_yucky,
    output logic [CNT_W-1:0] stat_illegal,
    input  logic             stat_clear
);

    logic [2:0] s1_flavor;
    color_e     s1_color;
    logic       s1_sugar_free;
    logic       s1_sour;
    logic       s1_unused;

    taste_e     taste_q, taste_n;
    logic [3:0] sour_run, sour_run_n;
    logic [3:0] numb_cnt;
    logic       present, illegal, numb_load;

    logic [NUM_FLAVORS-1:0]            inc_yummy, inc_yucky;
    logic [NUM_FLAVORS-1:0][CNT_W-1:0] yummy_cnt, yucky_cnt;
    logic [1:0]                        sel_idx;

    // Color and sugar_free ride along in stage 1 but never influence taste.
    assign s1_unused = ^{s1_color, s1_sugar_free};

    always_comb begin
        present    = is_present(s1_flavor);
        illegal    = s1_flavor > 3'd4;
        taste_n    = NO_TASTE;
        sour_run_n = sour_run;
        numb_load  = 1'b0;
        if (present) begin
            if (numb_cnt != 4'd0)
                taste_n = YUCKY;
            else if ((s1_flavor == 3'(CHOCOLATE)) && s1_sour)
                taste_n = YUCKY;
            else
                taste_n = YUMMY;

            if (numb_cnt != 4'd0)
                sour_run_n = 4'd0;
            else if (s1_sour) begin
                if (sour_run + 4'd1 == 4'(SOUR_LIMIT)) begin
                    numb_load  = 1'b1;
                    sour_run_n = 4'd0;
                end else begin
                    sour_run_n = sour_run + 4'd1;
                end
            end else begin
                sour_run_n = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_flavor     <= 3'(NO_FLAVOR);
            s1_color      <= RED;
            s1_sugar_free <= 1'b0;
            s1_sour       <= 1'b0;
            taste_q       <= NO_TASTE;
            sour_run      <= 4'd0;
            numb_cnt      <= 4'd0;
        end else begin
            s1_flavor     <= flavor;
            s1_color      <= color_e'(color);
            s1_sugar_free <= sugar_free;
            s1_sour       <= sour;
            taste_q       <= taste_n;
            sour_run      <= sour_run_n;
            // The load edge wins over the per-edge countdown.
            if (numb_load)
                numb_cnt <= 4'(NUMB_CYCLES);
            else if (numb_cnt != 4'd0)
                numb_cnt <= numb_cnt - 4'd1;
        end
    end

    assign taste = taste_q;
    assign numb  = (numb_cnt != 4'd0);

    for (genvar f = 0; f < NUM_FLAVORS; f++) begin : g_flavor
        assign inc_yummy[f] = present && (s1_flavor == 3'(f + 1)) && (taste_n == YUMMY);
        assign inc_yucky[f] = present && (s1_flavor == 3'(f + 1)) && (taste_n == YUCKY);

        jelly_bean_stat_counter #(.CNT_W(CNT_W)) u_yummy (
            .clk   (clk),
            .reset (reset),
            .clear (stat_clear),
            .inc   (inc_yummy[f]),
            .count (yummy_cnt[f])
        );

        jelly_bean_stat_counter #(.CNT_W(CNT_W)) u_yucky (
            .clk   (clk),
            .reset (reset),
            .clear (stat_clear),
            .inc   (inc_yucky[f]),
            .count (yucky_cnt[f])
        );
    end

    jelly_bean_stat_counter #(.CNT_W(CNT_W)) u_illegal (
        .clk   (clk),
        .reset (reset),
        .clear (stat_clear),
        .inc   (illegal),
        .count (stat_illegal)
    );

    assign sel_idx = 2'(stat_sel - 3'd1);

    always_comb begin
        stat_yummy = '0;
        stat_yucky = '0;
        if (is_present(stat_sel)) begin
            stat_yummy = yummy_cnt[sel_idx];
            stat_yucky = yucky_cnt[sel_idx];
        end
    end

endmodule

// File: tb/tb_jelly_bean_taster_core.sv
// Directed-vector bench: stimulus pushes expected tastes, a monitor pops and compares.
module tb_jelly_bean_taster_core;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       flavor;
    logic [1:0]       color;
    logic             sugar_free;
    logic             sour;
    logic [1:0]       taste;
    logic             numb;
    logic [2:0]       stat_sel;
    logic [CNT_W-1:0] stat_yummy;
    logic [CNT_W-1:0] stat_yucky;
    logic [CNT_W-1:0] stat_illegal;
    logic             stat_clear;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    jelly_bean_taster_core #(.SOUR_LIMIT(3), .NUMB_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flavor       (flavor),
        .color        (color),
        .sugar_free   (sugar_free),
        .sour         (sour),
        .taste        (taste),
        .numb         (numb),
        .stat_sel     (stat_sel),
        .stat_yummy   (stat_yummy),
        .stat_yucky   (stat_yucky),
        .stat_illegal (stat_illegal),
        .stat_clear   (stat_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // One bus cycle; expv > 0 is the taste this bean must produce two edges later.
    task automatic cyc(input int flv, input bit sr, input int expv, input bit clr, input bit rst);
        flavor     = 3'(flv);
        sour       = sr;
        color      = 2'(flv % 3);
        sugar_free = sr;
        stat_clear = clr;
        reset      = rst;
        if (expv > 0) exp_q.push_back(expv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!$isunknown(taste) && taste != 2'd0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL taste_extra: got %0d expected none", taste);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(taste) != e) begin
                    bad++;
                    $display("FAIL taste_seq: got %0d expected %0d", taste, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flavor = '0; color = '0; sugar_free = 1'b0; sour = 1'b0;
        stat_clear = 1'b0; stat_sel = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_taste", taste, 0);
        chk("rst_numb", numb, 0);
        chk("rst_illegal", stat_illegal, 0);
        chk("rst_yummy", stat_yummy, 0);

        // Single APPLE bean
        cyc(1, 0, 1, 0, 0);
        chk("t1_after_e0", taste, 0);
        idle(1);
        chk("t1_after_e1", taste, 1);
        idle(1);
        chk("t1_after_e2", taste, 0);
        stat_sel = 3'd1;
        #1 chk("t1_yummy", stat_yummy, 1);
        chk("t1_yucky", stat_yucky, 0);

        // Sour then sweet CHOCOLATE
        cyc(0, 0, 0, 1, 0);
        cyc(4, 1, 2, 0, 0);
        cyc(4, 0, 1, 0, 0);
        chk("t2_after_e1", taste, 2);
        idle(1);
        chk("t2_after_e2", taste, 1);
        idle(1);
        stat_sel = 3'd4;
        #1 chk("t2_yucky", stat_yucky, 1);
        chk("t2_yummy", stat_yummy, 1);

        // Sour fatigue: 3 sour APPLE, then 5 plain APPLE
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, (i < 3), (i < 3 || i == 7) ? 1 : 2, 0, 0);
            chk($sformatf("t3_numb_%0d", i), numb, (i >= 3 && i <= 6) ? 1 : 0);
        end
        idle(2);
        stat_sel = 3'd1;
        #1 chk("t3_yummy", stat_yummy, 4);
        chk("t3_yucky", stat_yucky, 4);

        // Saturation with CNT_W=4 and clear on the final increment edge
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(2, 0, 1, 0, 0);
        stat_sel = 3'd2;
        #1 chk("t4_sat", stat_yummy, 15);
        cyc(0, 0, 0, 1, 0);
        chk("t4_clear_wins", stat_yummy, 0);
        chk("t4_yucky", stat_yucky, 0);
        idle(2);

        // Illegal flavor between sour beans must not disturb sour_run
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(6, 1, 0, 0, 0);
        cyc(6, 1, 0, 0, 0);
        chk("t5_illegal_taste_a", taste, 0);
        cyc(6, 1, 0, 0, 0);
        chk("t5_illegal_taste_b", taste, 0);
        cyc(1, 1, 1, 0, 0);
        chk("t5_illegal_taste_c", taste, 0);
        cyc(1, 0, 2, 0, 0);
        chk("t5_numb_on", numb, 1);
        idle(6);
        chk("t5_numb_off", numb, 0);
        chk("t5_illegal_cnt", stat_illegal, 3);
        stat_sel = 3'd1;
        #1 chk("t5_yummy", stat_yummy, 3);
        chk("t5_yucky", stat_yucky, 1);

        // Reset mid-stream drops in-flight bean and fatigue history
        cyc(0, 0, 0, 1, 0);
        cyc(3, 1, 1, 0, 0);
        cyc(3, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        stat_sel = 3'd3;
        #1 chk("t6_taste_rst", taste, 0);
        chk("t6_yummy_rst", stat_yummy, 0);
        cyc(3, 1, 1, 0, 0);
        cyc(3, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("t6_numb_%0d", i), numb, 0);
        end
        chk("t6_yummy", stat_yummy, 2);

        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
